// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: pixel-clock divider, x/y scan counters,
// registered de/hsync/vsync aligned to x/y, line/frame strobes and a frame counter.
module video_timing_gen #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int CLK_DIV   = 4,
  parameter bit HS_POL    = 1'b0,
  parameter bit VS_POL    = 1'b0,
  parameter int CW        = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  output logic          p_tick,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          de,
  output logic          hsync,
  output logic          vsync,
  output logic          line_start,
  output logic          frame_start,
  output logic [7:0]    frame_count
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);

  // Window bounds carry one extra bit so an end bound equal to 2^CW cannot wrap to zero.
  localparam logic [CW:0] H_DE_END = (CW+1)'(H_DISPLAY);
  localparam logic [CW:0] H_SY_BEG = (CW+1)'(H_DISPLAY + H_FRONT);
  localparam logic [CW:0] H_SY_END = (CW+1)'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [CW:0] V_DE_END = (CW+1)'(V_DISPLAY);
  localparam logic [CW:0] V_SY_BEG = (CW+1)'(V_DISPLAY + V_FRONT);
  localparam logic [CW:0] V_SY_END = (CW+1)'(V_DISPLAY + V_FRONT + V_SYNC);

  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
  } decode_t;

  function automatic decode_t decode(input logic [CW-1:0] px, input logic [CW-1:0] py);
    decode_t r;
    logic    hs_act;
    logic    vs_act;
    hs_act = ({1'b0, px} >= H_SY_BEG) && ({1'b0, px} < H_SY_END);
    vs_act = ({1'b0, py} >= V_SY_BEG) && ({1'b0, py} < V_SY_END);
    r.de   = ({1'b0, px} < H_DE_END) && ({1'b0, py} < V_DE_END);
    r.hs   = hs_act ? HS_POL : ~HS_POL;
    r.vs   = vs_act ? VS_POL : ~VS_POL;
    return r;
  endfunction

  logic [DW-1:0] div_q, div_d;
  logic [CW-1:0] x_q, x_d;
  logic [CW-1:0] y_q, y_d;
  logic [7:0]    fc_q, fc_d;
  logic          de_q, de_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          pix_tick;
  decode_t       dec_d;

  assign pix_tick = en && (div_q == '0);

  // Next-state: divider, scan position, frame count, and decode of the next position.
  always_comb begin
    div_d = div_q;
    x_d   = x_q;
    y_d   = y_q;
    fc_d  = fc_q;

    if (en) begin
      if (div_q == DIV_LAST) begin
        div_d = '0;
      end else begin
        div_d = div_q + DW'(1);
      end
    end else begin
      div_d = div_q;
    end

    if (pix_tick) begin
      if (x_q == H_LAST) begin
        x_d = '0;
        if (y_q == V_LAST) begin
          y_d  = '0;
          fc_d = fc_q + 8'd1;
        end else begin
          y_d  = y_q + CW'(1);
        end
      end else begin
        x_d = x_q + CW'(1);
      end
    end else begin
      x_d = x_q;
    end

    // Decoding the next position keeps the registered syncs in step with x/y.
    dec_d   = decode(x_d, y_d);
    de_d    = dec_d.de;
    hsync_d = dec_d.hs;
    vsync_d = dec_d.vs;
  end

  // State register with asynchronous reset to the idle raster position.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      fc_q    <= 8'd0;
      de_q    <= 1'b0;
      hsync_q <= ~HS_POL;
      vsync_q <= ~VS_POL;
    end else begin
      div_q   <= div_d;
      x_q     <= x_d;
      y_q     <= y_d;
      fc_q    <= fc_d;
      de_q    <= de_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
    end
  end

  assign p_tick      = pix_tick;
  assign x           = x_q;
  assign y           = y_q;
  assign de          = de_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign line_start  = pix_tick && (x_q == '0);
  assign frame_start = pix_tick && (x_q == '0) && (y_q == '0);
  assign frame_count = fc_q;

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
Parametrised raster timing generator that replaces the fixed 640x480 sync unit. It has a configurable pixel-clock divider, porch, sync and display geometry, and sync polarity. It adds a run enable, a registered display-enable, line/frame start strobes and a frame counter. It sits between the system clock and every renderer; renderers consume x/y/p_tick and the pins take hsync/vsync.

Parameters:
H_DISPLAY, 640, active pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_DISPLAY, 480, active lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BACK, 33, vertical back porch (lines)
CLK_DIV, 4, clk cycles per pixel; legal range 1..16
HS_POL, 0, hsync active level (0 = active-low)
VS_POL, 0, vsync active level
CW, 10, x/y counter width; must satisfy 2^CW >= H_TOTAL and 2^CW >= V_TOTAL

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
en  input  1  run enable; low freezes all timing state
p_tick  output  1  one-clk pixel strobe
x  output  CW  current column, 0..H_TOTAL-1
y  output  CW  current line, 0..V_TOTAL-1
de  output  1  registered display enable
hsync  output  1  registered horizontal sync, polarity HS_POL
vsync  output  1  registered vertical sync, polarity VS_POL
line_start  output  1  one-clk strobe at the first pixel of each line
frame_start  output  1  one-clk strobe at pixel (0,0) of each frame
frame_count  output  8  frames completed, modulo 256

Behaviour:
- Derived constants: H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800 default); V_TOTAL likewise (525 default).
- Reset values: divider=0, x=0, y=0, frame_count=0, de=0, hsync=~HS_POL, vsync=~VS_POL.
- Divider: counts 0..CLK_DIV-1 and wraps, advancing only while en=1.
  - p_tick = en && divider==0 (combinational).
  - CLK_DIV=1: p_tick equals en.
- Counters update only on clk edges where p_tick=1:
  - x increments; at x==H_TOTAL-1, x goes to 0 and y increments.
  - At y==V_TOTAL-1 and x==H_TOTAL-1, both go to 0 and frame_count increments. frame_count wraps 255 -> 0.
- Decode of a position (px,py):
  - de = px<H_DISPLAY && py<V_DISPLAY.
  - hsync active when H_DISPLAY+H_FRONT <= px < H_DISPLAY+H_FRONT+H_SYNC.
  - vsync active when V_DISPLAY+V_FRONT <= py < V_DISPLAY+V_FRONT+V_SYNC.
- de/hsync/vsync registers load, every clk, the decode of the counters' next-state values.
  - Invariant: from the first clk edge after reset release, de/hsync/vsync always equal decode(x,y) in the same cycle. There is zero relative latency between position and sync.
- line_start = p_tick && x==0. frame_start = p_tick && x==0 && y==0. Both combinational from registers.
- en=0: divider, x, y and frame_count hold; p_tick, line_start and frame_start are 0; de/hsync/vsync keep decode(x,y). On en rising, counting resumes from the held position; the first p_tick occurs when divider==0.
- Reset mid-frame: immediate return to reset values, asynchronously. The first p_tick comes on the first clk where reset=0 and en=1, at x=0,y=0, and it raises frame_start.
- No sync registers on en; it is synchronous to clk.

Test Plan:
- Defaults: reset, then en=1 -> p_tick every 4th clk, first at release; de=1, hsync=1, vsync=1 at (0,0); frame_count=0.
- Hsync window: run one line -> hsync=0 exactly for x=656..751 (96 ticks); de=0 for x>=640; line_start once per 800 ticks at x=0.
- Frame wrap: run to (799,524) -> next tick gives (0,0), frame_count 0->1, frame_start pulse; vsync=0 only for y=490..491; de=0 for y>=480.
- Enable freeze: drop en at (100,20) for 37 clks -> no p_tick, x/y/frame_count hold, hsync/de unchanged; raise en -> continues to (101,20).
- Mid-frame reset at (300,200) -> x=y=0, de=0, hsync=vsync=1 asynchronously; after release the first tick asserts frame_start.
- Variant CLK_DIV=1, HS_POL=1, VS_POL=1, H_DISPLAY=800, CW=11 -> p_tick=en continuously; hsync high only in the sync window; 256 frames wraps frame_count to 0.
